freq_meter: RTL

//  Gated-window frequency meter; the measuring counterpart to the board's clock dividers.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/freq_meter_edge_sync_detect.sv | 56 +++++
 rtl/freq_meter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated-window frequency meter.
package freq_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } state_t;

    // Consecutive equal samples required by the optional glitch filter
    localparam int unsigned FILT_LEN = 3;

endpackage

// File: rtl/freq_meter_edge_sync_detect.sv
// Synchroniser, optional stability filter and rising-edge strobe for an async input.
// Optional feature: FREQ_METER_GLITCH_FILTER_EN adds a FILT_LEN-sample stability filter.
module edge_sync_detect
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic BOARD_CLK,
    input  logic BOARD_RSTN,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_q;

    // Metastability synchroniser chain
    always_ff @(posedge BOARD_CLK or negedge BOARD_RSTN) begin
        if (!BOARD_RSTN) sync_q <= '0;
        else             sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

`ifdef FREQ_METER_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] hist_q;
    logic                filt_q;
    logic [FILT_LEN-1:0] window;

    assign window = {hist_q, sync_q[SYNC_STAGES-1]};

    // Filtered level follows the input only after FILT_LEN equal samples
    always_ff @(posedge BOARD_CLK or negedge BOARD_RSTN) begin
        if (!BOARD_RSTN) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= window[FILT_LEN-2:0];
            if (window == '1)      filt_q <= 1'b1;
            else if (window == '0) filt_q <= 1'b0;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Previous level for edge detection
    always_ff @(posedge BOARD_CLK or negedge BOARD_RSTN) begin
        if (!BOARD_RSTN) lvl_q <= 1'b0;
        else             lvl_q <= lvl;
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts rising edges of sig_in per GATE_CYCLES window.
// Optional feature: FREQ_METER_GLITCH_FILTER_EN (stability filter, longer SETTLE).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             BOARD_CLK,
    input  logic             BOARD_RSTN,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
`ifdef FREQ_METER_GLITCH_FILTER_EN
    localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + FILT_LEN;
`else
    localparam int unsigned SETTLE_CYCLES = SYNC_STAGES;
`endif
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               wovf_q, wovf_d;
    logic [CNT_W-1:0]   freq_d;
    logic               ovf_d;
    logic               valid_d;
    logic               rise;
    logic               at_max;
    logic [CNT_W-1:0]   sum_sat;
    logic               sum_ovf;

    edge_sync_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .BOARD_CLK  (BOARD_CLK),
        .BOARD_RSTN (BOARD_RSTN),
        .d          (sig_in),
        .rise       (rise)
    );

    // State, counters and output registers
    always_ff @(posedge BOARD_CLK or negedge BOARD_RSTN) begin
        if (!BOARD_RSTN) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            settle_q   <= '0;
            edge_q     <= '0;
            wovf_q     <= 1'b0;
            freq_out   <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            settle_q   <= settle_d;
            edge_q     <= edge_d;
            wovf_q     <= wovf_d;
            freq_out   <= freq_d;
            overflow   <= ovf_d;
            freq_valid <= valid_d;
        end
    end

    // Next-state, saturating edge count and window close
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        settle_d = settle_q;
        edge_d   = edge_q;
        wovf_d   = wovf_q;
        freq_d   = freq_out;
        ovf_d    = overflow;
        valid_d  = 1'b0;

        at_max  = (edge_q == CNT_MAX);
        sum_sat = (rise && !at_max) ? edge_q + CNT_W'(1) : edge_q;
        sum_ovf = wovf_q | (rise & at_max);

        case (state_q)
            IDLE: begin
                gate_d   = '0;
                settle_d = '0;
                edge_d   = '0;
                wovf_d   = 1'b0;
                if (en) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = GATE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            GATE: begin
                if (gate_q == GATE_W'(GATE_CYCLES - 1)) begin
                    freq_d  = sum_sat;
                    ovf_d   = sum_ovf;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    wovf_d  = 1'b0;
                end else begin
                    gate_d  = gate_q + GATE_W'(1);
                    edge_d  = sum_sat;
                    wovf_d  = sum_ovf;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable discards the partial window but keeps the last result
        if (!en) begin
            state_d  = IDLE;
            gate_d   = '0;
            settle_d = '0;
            edge_d   = '0;
            wovf_d   = 1'b0;
            valid_d  = 1'b0;
            freq_d   = freq_out;
            ovf_d    = overflow;
        end
    end

endmodule
